// File: rtl/hamming_minmax_engine.sv
// Min/max pairwise Hamming distance engine: loads n operands from byte memory,
// scans every pair once, then writes the extremes and their index pairs back.
module hamming_minmax_engine #(
    parameter int WORD_W   = 16,
    parameter int MEM_W    = 8,
    parameter int N_MAX    = 32,
    parameter int ADDR_W   = 8,
    parameter int SRC_BASE = 0,
    parameter int RES_BASE = 64,
    localparam int BPW = WORD_W / MEM_W,
    localparam int DW  = $clog2(WORD_W + 1),
    localparam int IW  = $clog2(N_MAX)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [IW:0]       n_words,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [MEM_W-1:0]  mem_rd_data,
    output logic              mem_we,
    output logic [MEM_W-1:0]  mem_wr_data,
    output logic              busy,
    output logic              done,
    output logic [DW-1:0]     min_dist,
    output logic [DW-1:0]     max_dist,
    output logic [IW-1:0]     min_a,
    output logic [IW-1:0]     min_b,
    output logic [IW-1:0]     max_a,
    output logic [IW-1:0]     max_b
);

    localparam int CW = $clog2(N_MAX * BPW + 1);
    localparam int PW = (BPW > 1) ? $clog2(BPW) : 1;

    localparam logic [IW:0]       N_ONE = (IW + 1)'(32'd1);
    localparam logic [IW:0]       N_TWO = (IW + 1)'(32'd2);
    localparam logic [IW:0]       N_CAP = (IW + 1)'(N_MAX);
    localparam logic [IW-1:0]     I_ONE = IW'(32'd1);
    localparam logic [IW-1:0]     I_TWO = IW'(32'd2);
    localparam logic [CW-1:0]     C_ONE = CW'(32'd1);
    localparam logic [PW-1:0]     P_ONE = PW'(32'd1);
    localparam logic [PW-1:0]     P_LAST = PW'(BPW - 1);
    localparam logic [ADDR_W-1:0] A_ONE = ADDR_W'(32'd1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_CMP   = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t state_r, state_s;

    logic              start_prev_r;
    logic [IW:0]       n_eff_r;
    logic [CW-1:0]     ld_cnt_r;
    logic [IW-1:0]     cap_idx_r;
    logic [PW-1:0]     cap_pos_r;
    logic [WORD_W-1:0] ops_r [N_MAX];
    logic [IW-1:0]     j_r, k_r;
    logic [2:0]        wr_cnt_r;
    logic [DW-1:0]     wmin_r, wmax_r;
    logic [IW-1:0]     wmin_a_r, wmin_b_r, wmax_a_r, wmax_b_r;

    logic              launch_s, load_last_s, k_end_s, cmp_last_s, write_last_s, enter_write_s;
    logic [CW-1:0]     load_len_s;
    logic [DW-1:0]     dist_s, wmin_nx_s, wmax_nx_s;
    logic [IW-1:0]     wmin_a_nx_s, wmin_b_nx_s, wmax_a_nx_s, wmax_b_nx_s;

    function automatic logic [DW-1:0] popcount(input logic [WORD_W-1:0] v);
        logic [DW-1:0] c;
        c = '0;
        for (int i = 0; i < WORD_W; i++) begin
            c = c + DW'(v[i]);
        end
        return c;
    endfunction

    function automatic logic [MEM_W-1:0] wr_sel(input logic [2:0] sel,
                                                input logic [DW-1:0] dmin, dmax,
                                                input logic [IW-1:0] ia, ib, xa, xb);
        case (sel)
            3'd0:    return MEM_W'(dmin);
            3'd1:    return MEM_W'(dmax);
            3'd2:    return MEM_W'(ia);
            3'd3:    return MEM_W'(ib);
            3'd4:    return MEM_W'(xa);
            3'd5:    return MEM_W'(xb);
            default: return '0;
        endcase
    endfunction

    assign launch_s      = (state_r == S_IDLE) && start_prev_r && !start;
    assign load_len_s    = CW'(n_eff_r) * CW'(BPW);
    assign load_last_s   = (ld_cnt_r == load_len_s);
    assign k_end_s       = ({1'b0, k_r} == n_eff_r - N_ONE);
    assign cmp_last_s    = k_end_s && ({1'b0, j_r} == n_eff_r - N_TWO);
    assign write_last_s  = (wr_cnt_r == 3'd5);
    assign enter_write_s = (state_s == S_WRITE) && (state_r != S_WRITE);

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (launch_s) state_s = S_LOAD;
                else          state_s = S_IDLE;
            end
            S_LOAD: begin
                if (load_last_s) state_s = (n_eff_r < N_TWO) ? S_WRITE : S_CMP;
                else             state_s = S_LOAD;
            end
            S_CMP: begin
                if (cmp_last_s) state_s = S_WRITE;
                else            state_s = S_CMP;
            end
            S_WRITE: begin
                if (write_last_s) state_s = S_DONE;
                else              state_s = S_WRITE;
            end
            S_DONE: begin
                if (start) state_s = S_IDLE;
                else       state_s = S_DONE;
            end
            default: state_s = S_IDLE;
        endcase
    end

    // Pair distance and working extreme update; strict compares keep the first pair on ties
    always_comb begin
        dist_s      = popcount(ops_r[j_r] ^ ops_r[k_r]);
        wmin_nx_s   = wmin_r;
        wmin_a_nx_s = wmin_a_r;
        wmin_b_nx_s = wmin_b_r;
        wmax_nx_s   = wmax_r;
        wmax_a_nx_s = wmax_a_r;
        wmax_b_nx_s = wmax_b_r;
        if ((state_r == S_CMP) && (dist_s < wmin_r)) begin
            wmin_nx_s   = dist_s;
            wmin_a_nx_s = j_r;
            wmin_b_nx_s = k_r;
        end else begin
            wmin_nx_s   = wmin_r;
            wmin_a_nx_s = wmin_a_r;
            wmin_b_nx_s = wmin_b_r;
        end
        if ((state_r == S_CMP) && (dist_s > wmax_r)) begin
            wmax_nx_s   = dist_s;
            wmax_a_nx_s = j_r;
            wmax_b_nx_s = k_r;
        end else begin
            wmax_nx_s   = wmax_r;
            wmax_a_nx_s = wmax_a_r;
            wmax_b_nx_s = wmax_b_r;
        end
    end

    // Operand cache: bytes shift in most significant first, so BPW captures rebuild a word
    always_ff @(posedge clk) begin
        if (reset_n && (state_r == S_LOAD) && (ld_cnt_r != '0)) begin
            ops_r[cap_idx_r] <= (ops_r[cap_idx_r] << MEM_W) | WORD_W'(mem_rd_data);
        end
    end

    // Control counters, working extremes, memory port and result registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            start_prev_r <= 1'b0;
            n_eff_r      <= '0;
            ld_cnt_r     <= '0;
            cap_idx_r    <= '0;
            cap_pos_r    <= '0;
            j_r          <= '0;
            k_r          <= '0;
            wr_cnt_r     <= '0;
            wmin_r       <= DW'(WORD_W);
            wmax_r       <= '0;
            wmin_a_r     <= '0;
            wmin_b_r     <= '0;
            wmax_a_r     <= '0;
            wmax_b_r     <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wr_data  <= '0;
            min_dist     <= DW'(WORD_W);
            max_dist     <= '0;
            min_a        <= '0;
            min_b        <= '0;
            max_a        <= '0;
            max_b        <= '0;
        end else begin
            start_prev_r <= start;
            case (state_r)
                S_IDLE: begin
                    if (launch_s) begin
                        n_eff_r   <= (n_words > N_CAP) ? N_CAP : n_words;
                        ld_cnt_r  <= '0;
                        cap_idx_r <= '0;
                        cap_pos_r <= '0;
                        wmin_r    <= DW'(WORD_W);
                        wmax_r    <= '0;
                        wmin_a_r  <= '0;
                        wmin_b_r  <= '0;
                        wmax_a_r  <= '0;
                        wmax_b_r  <= '0;
                        busy      <= 1'b1;
                        mem_addr  <= ADDR_W'(SRC_BASE);
                    end
                end
                S_LOAD: begin
                    ld_cnt_r <= ld_cnt_r + C_ONE;
                    if ((ld_cnt_r + C_ONE) < load_len_s) begin
                        mem_addr <= ADDR_W'(SRC_BASE) + ADDR_W'(ld_cnt_r) + A_ONE;
                    end
                    if (ld_cnt_r != '0) begin
                        if (cap_pos_r == P_LAST) begin
                            cap_pos_r <= '0;
                            cap_idx_r <= cap_idx_r + I_ONE;
                        end else begin
                            cap_pos_r <= cap_pos_r + P_ONE;
                        end
                    end
                    j_r <= '0;
                    k_r <= I_ONE;
                end
                S_CMP: begin
                    wmin_r   <= wmin_nx_s;
                    wmin_a_r <= wmin_a_nx_s;
                    wmin_b_r <= wmin_b_nx_s;
                    wmax_r   <= wmax_nx_s;
                    wmax_a_r <= wmax_a_nx_s;
                    wmax_b_r <= wmax_b_nx_s;
                    if (k_end_s) begin
                        j_r <= j_r + I_ONE;
                        k_r <= j_r + I_TWO;
                    end else begin
                        k_r <= k_r + I_ONE;
                    end
                end
                S_WRITE: begin
                    if (write_last_s) begin
                        mem_we      <= 1'b0;
                        mem_addr    <= '0;
                        mem_wr_data <= '0;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        min_dist    <= wmin_r;
                        max_dist    <= wmax_r;
                        min_a       <= wmin_a_r;
                        min_b       <= wmin_b_r;
                        max_a       <= wmax_a_r;
                        max_b       <= wmax_b_r;
                    end else begin
                        wr_cnt_r    <= wr_cnt_r + 3'd1;
                        mem_addr    <= ADDR_W'(RES_BASE) + ADDR_W'(wr_cnt_r) + A_ONE;
                        mem_wr_data <= wr_sel(wr_cnt_r + 3'd1, wmin_r, wmax_r,
                                              wmin_a_r, wmin_b_r, wmax_a_r, wmax_b_r);
                    end
                end
                S_DONE: begin
                    if (start) done <= 1'b0;
                end
                default: ;
            endcase
            // The final pair's update is folded into the first result byte
            if (enter_write_s) begin
                mem_we      <= 1'b1;
                mem_addr    <= ADDR_W'(RES_BASE);
                mem_wr_data <= MEM_W'(wmin_nx_s);
                wr_cnt_r    <= '0;
            end
        end
    end

endmodule

// File: tb/tb_hamming_minmax_engine.sv
// Bench for hamming_minmax_engine: byte memory model, write logger and a
// brute-force pairwise popcount reference.
module tb_hamming_minmax_engine;

    localparam int WORD_W   = 16;
    localparam int MEM_W    = 8;
    localparam int N_MAX    = 32;
    localparam int IW       = 5;
    localparam int DW       = 5;
    localparam int RES_BASE = 64;

    logic          clk = 1'b0;
    logic          reset_n, start;
    logic [IW:0]   n_words;
    logic [7:0]    mem_addr, rd_data, mem_wr_data;
    logic          mem_we, busy, done;
    logic [DW-1:0] min_dist, max_dist;
    logic [IW-1:0] min_a, min_b, max_a, max_b;

    logic [15:0]   opnd [N_MAX];
    int            wr_n = 0;
    logic [7:0]    wr_addr_log [1024];
    logic [7:0]    wr_data_log [1024];
    logic [31:0]   exp_v [6];
    logic [31:0]   act_v [6];
    int            vectors = 0;
    int            miscompares = 0;

    always #5 clk = ~clk;

    hamming_minmax_engine #(
        .WORD_W(WORD_W), .MEM_W(MEM_W), .N_MAX(N_MAX),
        .ADDR_W(8), .SRC_BASE(0), .RES_BASE(RES_BASE)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .n_words(n_words),
        .mem_addr(mem_addr), .mem_rd_data(rd_data), .mem_we(mem_we),
        .mem_wr_data(mem_wr_data), .busy(busy), .done(done),
        .min_dist(min_dist), .max_dist(max_dist),
        .min_a(min_a), .min_b(min_b), .max_a(max_a), .max_b(max_b)
    );

    function automatic logic [7:0] rd_byte(input logic [7:0] a);
        logic [15:0] w;
        if (a < 8'd64) begin
            w = opnd[a[5:1]];
            return a[0] ? w[7:0] : w[15:8];
        end
        return 8'hEE;
    endfunction

    always @(posedge clk) begin
        rd_data <= rd_byte(mem_addr);
        if (mem_we === 1'b1) begin
            wr_addr_log[wr_n % 1024] <= mem_addr;
            wr_data_log[wr_n % 1024] <= mem_wr_data;
            wr_n <= wr_n + 1;
        end
    end

    function automatic void model(input int n);
        int ne, d, mn, mx, ia, ib, xa, xb;
        ne = (n > N_MAX) ? N_MAX : n;
        mn = WORD_W; mx = 0; ia = 0; ib = 0; xa = 0; xb = 0;
        for (int j = 0; j < ne; j++) begin
            for (int k = j + 1; k < ne; k++) begin
                d = $countones(opnd[j] ^ opnd[k]);
                if (d < mn) begin mn = d; ia = j; ib = k; end
                if (d > mx) begin mx = d; xa = j; xb = k; end
            end
        end
        exp_v[0] = mn; exp_v[1] = mx; exp_v[2] = ia;
        exp_v[3] = ib; exp_v[4] = xa; exp_v[5] = xb;
    endfunction

    function automatic int lat(input int n);
        int ne;
        ne = (n > N_MAX) ? N_MAX : n;
        return 1 + (ne * 2 + 1) + ne * (ne - 1) / 2 + 6;
    endfunction

    function automatic void snap();
        act_v[0] = 32'(min_dist); act_v[1] = 32'(max_dist); act_v[2] = 32'(min_a);
        act_v[3] = 32'(min_b);    act_v[4] = 32'(max_a);    act_v[5] = 32'(max_b);
    endfunction

    function automatic void fill_random();
        for (int i = 0; i < N_MAX; i++) opnd[i] = 16'($urandom);
    endfunction

    task automatic run(input int n, output int cyc, output int base);
        n_words = 6'(n);
        start = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        base  = wr_n;
        start = 1'b0;
        cyc   = 0;
        while (done !== 1'b1 && cyc < 800) begin
            @(posedge clk); #1; cyc++;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b1; n_words = 6'd0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({busy, done, mem_we} !== 3'b000) begin
            miscompares++; $display("FAIL reset_ctrl: got %b expected 000", {busy, done, mem_we});
        end
        vectors++;
        if ({mem_addr, mem_wr_data} !== 16'h0000) begin
            miscompares++; $display("FAIL reset_mem: got %h expected 0000", {mem_addr, mem_wr_data});
        end
        vectors++;
        if ({min_dist, max_dist} !== {5'd16, 5'd0}) begin
            miscompares++; $display("FAIL reset_dist: got min %0d max %0d expected 16 0", min_dist, max_dist);
        end
        vectors++;
        if ({min_a, min_b, max_a, max_b} !== 20'd0) begin
            miscompares++; $display("FAIL reset_idx: got %h expected 0", {min_a, min_b, max_a, max_b});
        end
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_directed();
        int cyc, base;
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < N_MAX; i++) opnd[i] = (p == 0) ? 16'h0000 : 16'hA5A5;
            if (p == 0) begin opnd[5] = 16'hFFFF; opnd[9] = 16'h0001; end
            run(32, cyc, base);
            model(32);
            snap();
            vectors++;
            if (cyc > 570) begin
                miscompares++; $display("FAIL directed%0d latency: got %0d cycles expected <= 570", p, cyc);
            end
            for (int i = 0; i < 6; i++) begin
                vectors++;
                if (act_v[i] !== exp_v[i]) begin
                    miscompares++; $display("FAIL directed%0d result%0d: got %0d expected %0d", p, i, act_v[i], exp_v[i]);
                end
            end
            vectors++;
            if (wr_n - base != 6) begin
                miscompares++; $display("FAIL directed%0d write_count: got %0d expected 6", p, wr_n - base);
            end
            for (int i = 0; i < 6; i++) begin
                vectors++;
                if (wr_addr_log[(base + i) % 1024] !== 8'(RES_BASE + i) || wr_data_log[(base + i) % 1024] !== exp_v[i][7:0]) begin
                    miscompares++;
                    $display("FAIL directed%0d mem%0d: got [%0d]=%0d expected [%0d]=%0d", p, i,
                             wr_addr_log[(base + i) % 1024], wr_data_log[(base + i) % 1024], RES_BASE + i, exp_v[i][7:0]);
                end
            end
        end
    endtask

    task automatic test_small_n();
        int cyc, base, n;
        for (int t = 0; t < 2; t++) begin
            n = (t == 0) ? 1 : 0;
            fill_random();
            run(n, cyc, base);
            model(n);
            snap();
            vectors++;
            if (cyc < lat(n) - 1 || cyc > lat(n) + 1) begin
                miscompares++; $display("FAIL small_n%0d latency: got %0d expected %0d", n, cyc, lat(n));
            end
            for (int i = 0; i < 6; i++) begin
                vectors++;
                if (act_v[i] !== exp_v[i]) begin
                    miscompares++; $display("FAIL small_n%0d result%0d: got %0d expected %0d", n, i, act_v[i], exp_v[i]);
                end
            end
            vectors++;
            if (wr_n - base != 6) begin
                miscompares++; $display("FAIL small_n%0d write_count: got %0d expected 6", n, wr_n - base);
            end
            for (int i = 0; i < 6; i++) begin
                vectors++;
                if (wr_addr_log[(base + i) % 1024] !== 8'(RES_BASE + i) || wr_data_log[(base + i) % 1024] !== exp_v[i][7:0]) begin
                    miscompares++; $display("FAIL small_n%0d mem%0d: got %0d expected %0d", n, i, wr_data_log[(base + i) % 1024], exp_v[i][7:0]);
                end
            end
        end
    endtask

    task automatic test_random();
        int cyc, base, n;
        for (int s = 0; s < 10; s++) begin
            fill_random();
            if (s % 3 == 1) for (int i = 0; i < N_MAX; i++) opnd[i] = opnd[i] & 16'h0F0F;
            n = (s < 5) ? 32 : $urandom_range(40, 2);
            run(n, cyc, base);
            model(n);
            snap();
            vectors++;
            if (cyc < lat(n) - 1 || cyc > lat(n) + 1) begin
                miscompares++; $display("FAIL random%0d latency: got %0d expected %0d (n=%0d)", s, cyc, lat(n), n);
            end
            for (int i = 0; i < 6; i++) begin
                vectors++;
                if (act_v[i] !== exp_v[i]) begin
                    miscompares++; $display("FAIL random%0d result%0d: got %0d expected %0d (n=%0d)", s, i, act_v[i], exp_v[i], n);
                end
            end
            vectors++;
            if (wr_n - base != 6) begin
                miscompares++; $display("FAIL random%0d write_count: got %0d expected 6", s, wr_n - base);
            end
            for (int i = 0; i < 6; i++) begin
                vectors++;
                if (wr_data_log[(base + i) % 1024] !== exp_v[i][7:0]) begin
                    miscompares++; $display("FAIL random%0d mem%0d: got %0d expected %0d", s, i, wr_data_log[(base + i) % 1024], exp_v[i][7:0]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_run();
        int cyc, base, bad;
        fill_random();
        n_words = 6'd32;
        start = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        start = 1'b0;
        base  = wr_n;
        repeat (150) @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if ({busy, done, mem_we, mem_addr, mem_wr_data} !== 19'd0) begin
            miscompares++; $display("FAIL midreset_ctrl: got %h expected 0", {busy, done, mem_we, mem_addr, mem_wr_data});
        end
        vectors++;
        if ({min_dist, max_dist, min_a, min_b, max_a, max_b} !== {5'd16, 5'd0, 20'd0}) begin
            miscompares++; $display("FAIL midreset_results: got min %0d max %0d expected 16 0", min_dist, max_dist);
        end
        reset_n = 1'b1;
        bad = 0;
        for (int c = 0; c < 700; c++) begin
            @(posedge clk); #1;
            if (mem_we !== 1'b0 || done !== 1'b0) bad++;
        end
        vectors++;
        if (bad != 0 || wr_n != base) begin
            miscompares++; $display("FAIL midreset_quiet: got %0d active cycles %0d writes expected 0 0", bad, wr_n - base);
        end
        fill_random();
        run(32, cyc, base);
        model(32);
        snap();
        vectors++;
        if (cyc > 570) begin
            miscompares++; $display("FAIL midreset_rerun latency: got %0d expected <= 570", cyc);
        end
        for (int i = 0; i < 6; i++) begin
            vectors++;
            if (act_v[i] !== exp_v[i] || wr_data_log[(base + i) % 1024] !== exp_v[i][7:0]) begin
                miscompares++; $display("FAIL midreset_rerun result%0d: got %0d expected %0d", i, act_v[i], exp_v[i]);
            end
        end
    endtask

    task automatic test_handshake();
        int cyc, base, bad;
        fill_random();
        run(20, cyc, base);
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (done !== 1'b1 || busy !== 1'b0) bad++;
        end
        vectors++;
        if (bad != 0 || wr_n - base != 6) begin
            miscompares++; $display("FAIL hold_low: got %0d bad cycles %0d writes expected 0 6", bad, wr_n - base);
        end
        start = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (done !== 1'b0) begin
            miscompares++; $display("FAIL done_drop: got %b expected 0", done);
        end
        fill_random();
        start = 1'b0;
        base  = wr_n;
        @(posedge clk); #1;
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++; $display("FAIL relaunch_busy: got %b expected 1", busy);
        end
        cyc = 1;
        while (done !== 1'b1 && cyc < 800) begin
            @(posedge clk); #1; cyc++;
        end
        model(20);
        snap();
        vectors++;
        if (cyc < lat(20) - 1 || cyc > lat(20) + 1) begin
            miscompares++; $display("FAIL relaunch latency: got %0d expected %0d", cyc, lat(20));
        end
        for (int i = 0; i < 6; i++) begin
            vectors++;
            if (act_v[i] !== exp_v[i]) begin
                miscompares++; $display("FAIL relaunch result%0d: got %0d expected %0d", i, act_v[i], exp_v[i]);
            end
        end
        // start pulses high while operands are still loading
        fill_random();
        n_words = 6'd32;
        start = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        start = 1'b0;
        base  = wr_n;
        cyc   = 0;
        while (done !== 1'b1 && cyc < 800) begin
            @(posedge clk); #1; cyc++;
            if (cyc == 10) start = 1'b1;
            if (cyc == 13) start = 1'b0;
        end
        model(32);
        snap();
        vectors++;
        if (cyc < lat(32) - 1 || cyc > lat(32) + 1 || wr_n - base != 6) begin
            miscompares++; $display("FAIL load_toggle timing: got %0d cycles %0d writes expected %0d 6", cyc, wr_n - base, lat(32));
        end
        for (int i = 0; i < 6; i++) begin
            vectors++;
            if (act_v[i] !== exp_v[i]) begin
                miscompares++; $display("FAIL load_toggle result%0d: got %0d expected %0d", i, act_v[i], exp_v[i]);
            end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        start   = 1'b1;
        n_words = 6'd0;
        test_reset();
        test_directed();
        test_small_n();
        test_random();
        test_reset_mid_run();
        test_handshake();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hamming_minmax_engine.md
Name: hamming_minmax_engine

Overview:
- Hardware engine for program 1: min and max pairwise Hamming distance over a block of operands in byte-wide data memory.
- Generalised over operand width, operand count and result location.
- Also reports the index pair that produced each extreme.
- Sits beside data memory under top_level and owns the memory port while busy.
- Runs on the start/done handshake used by the program-1 bench.

Parameters:
- WORD_W, 16: operand width in bits; must be a multiple of MEM_W and at least MEM_W.
- MEM_W, 8: data memory word width.
- N_MAX, 32: maximum operand count; sets internal cache depth.
- ADDR_W, 8: memory address width.
- SRC_BASE, 0: byte address of operand 0.
- RES_BASE, 64: byte address of the first result byte.
- Derived BPW = WORD_W/MEM_W.
- Derived DW = $clog2(WORD_W+1).
- Derived IW = $clog2(N_MAX).

Ports:
- clk, input, 1: clock, rising edge.
- reset_n, input, 1: synchronous active-low reset.
- start, input, 1: held high = hold idle; a high-to-low transition launches a run.
- n_words, input, IW+1: operand count, sampled at launch.
- mem_addr, output, ADDR_W: memory address.
- mem_rd_data, input, MEM_W: read data, valid one cycle after the address.
- mem_we, output, 1: memory write enable.
- mem_wr_data, output, MEM_W: memory write data.
- busy, output, 1: high from launch until done rises.
- done, output, 1: run complete.
- min_dist, output, DW: minimum Hamming distance.
- max_dist, output, DW: maximum Hamming distance.
- min_a, output, IW: lower index of the minimum pair.
- min_b, output, IW: higher index of the minimum pair.
- max_a, output, IW: lower index of the maximum pair.
- max_b, output, IW: higher index of the maximum pair.

Behaviour:
- Reset (reset_n low at a clk edge), regardless of state:
  - State goes to IDLE.
  - busy=0, done=0, mem_we=0, mem_addr=0, mem_wr_data=0.
  - min_dist=WORD_W, max_dist=0, all index outputs 0.
  - Reset mid-run abandons the run with no further memory writes.
- Launch: a registered copy of start tracks the previous value. Launch occurs in IDLE when start_prev=1 and start=0.
  - At launch, n_eff = min(n_words, N_MAX) is latched.
  - Working min is set to WORD_W, working max to 0.
  - busy rises the following cycle.
- States: IDLE -> LOAD -> CMP -> WRITE -> DONE -> IDLE.
- LOAD:
  - Issues addresses SRC_BASE .. SRC_BASE + n_eff*BPW - 1, one per cycle.
  - Captures mem_rd_data one cycle later.
  - Operand i = {mem[SRC_BASE+BPW*i], ..., mem[SRC_BASE+BPW*i+BPW-1]}, lowest address most significant.
  - Duration is n_eff*BPW + 1 cycles.
- CMP:
  - Evaluates one pair (j,k) per cycle, j outer loop, k = j+1 .. n_eff-1.
  - Duration is n_eff*(n_eff-1)/2 cycles.
  - dist = popcount(op[j] ^ op[k]), DW bits, no overflow possible.
  - dist < working min: update min and set (min_a,min_b) = (j,k).
  - dist > working max: update max and set (max_a,max_b) = (j,k).
  - Comparisons are strict, so on a tie the first pair in j-major order is kept.
- n_eff < 2: CMP is skipped. Results stay at min=WORD_W, max=0, indices 0.
- WRITE: six consecutive cycles with mem_we=1, writing to RES_BASE+0 .. +5 in this order: min_dist, max_dist, min_a, min_b, max_a, max_b. Each value is zero-extended to MEM_W.
- Output registers are updated at entry to DONE and hold until the next launch or reset.
- DONE: done=1 and busy=0. Remains in DONE while start=0. When start=1, goes to IDLE, clears done, and start_prev becomes 1.
- start rising during LOAD/CMP/WRITE is ignored; the run completes.
- mem_we is never high outside WRITE.
- Total latency from launch to done with defaults: 65 + 496 + 6 = 567 cycles, ±1 for the state registration.

Test Plan:
- Defaults, n_words=32. Operands 0..31 = 16'h0000 except op5 = 16'hFFFF and op9 = 16'h0001.
  - Expected: min_dist=0 at (0,1); max_dist=16 at (0,5).
  - Memory: [64]=0, [65]=16, [66..69]=0,1,0,5.
  - done within 570 cycles.
- All 32 operands identical (16'hA5A5): min=0 (0,1), max=0 with indices 0.
- Random operands, 10 seeds: all six results match a bench popcount model using strict-compare, first-pair tie rule.
- n_words=1, then separately n_words=0:
  - Expected: min_dist=16, max_dist=0, indices 0.
  - Exactly 6 writes occur; done follows LOAD + WRITE only.
- reset_n low for one cycle mid-CMP:
  - Outputs return to reset values and mem_we stays 0.
  - A subsequent start 1->0 completes correctly.
- Handshake:
  - start held low after done: no relaunch; done stays 1.
  - start 0->1->0: a second run launches, done drops on the first high cycle and reasserts at completion.
  - start toggled high mid-LOAD: the run is unaffected.
